// File: rtl/ppm_frame_ctrl.sv
// Frame-level sequencer for the PPM receive path: SOF detect, guard gap, whole-window
// decoder enable, MSB-first symbol-to-byte assembly, per-frame byte count and abort.
module ppm_frame_ctrl #(
    parameter int unsigned SYM_CLKS    = 8,
    parameter int unsigned FRAME_BYTES = 4,
    parameter int unsigned SOF_GAP     = 8
) (
    input  logic       clk16,
    input  logic       rst_n,
    input  logic       en,
    input  logic       Din,
    input  logic [2:0] data_3bits_in,
    input  logic       finish2bits_in,
    output logic       state_out,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       frame_done,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned WW = (SYM_CLKS > 1) ? $clog2(SYM_CLKS) : 1;

    typedef enum logic [1:0] {IDLE, GUARD, RECV, HOLDOFF} state_t;

    state_t          state;
    logic            din_n_r;
    logic [WW-1:0]   wcnt;
    logic [1:0]      sym_cnt;
    logic [7:0]      byte_cnt;
    logic [7:0]      gap;
    logic [7:0]      sh;
    logic            got;
    logic [1:0]      sym;

    logic            sym_ok_c;
    logic            last_win_c;
    logic            present_c;
    logic [1:0]      cur_sym_c;
    logic [7:0]      next_sh_c;

    // A finish landing in the closing cycle of a window still counts for that window.
    assign sym_ok_c   = finish2bits_in && !data_3bits_in[2];
    assign last_win_c = (wcnt == WW'(SYM_CLKS - 1));
    assign present_c  = got || sym_ok_c;
    assign cur_sym_c  = got ? sym : data_3bits_in[1:0];
    assign next_sh_c  = {sh[5:0], cur_sym_c};

    always_ff @(posedge clk16 or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            din_n_r    <= 1'b0;
            wcnt       <= '0;
            sym_cnt    <= '0;
            byte_cnt   <= '0;
            gap        <= '0;
            sh         <= '0;
            got        <= 1'b0;
            sym        <= '0;
            state_out  <= 1'b0;
            byte_out   <= '0;
            byte_valid <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            din_n_r    <= !Din;
            byte_valid <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (en && din_n_r) begin
                        state <= GUARD;
                        busy  <= 1'b1;
                        gap   <= '0;
                    end
                end
                GUARD: begin
                    if (gap == 8'(SOF_GAP - 1)) begin
                        state     <= RECV;
                        state_out <= 1'b1;
                        gap       <= '0;
                        wcnt      <= '0;
                        got       <= 1'b0;
                        sym_cnt   <= '0;
                        byte_cnt  <= '0;
                        sh        <= '0;
                    end else begin
                        gap <= gap + 8'd1;
                    end
                end
                RECV: begin
                    wcnt <= wcnt + WW'(1);
                    if (!last_win_c) begin
                        if (sym_ok_c && !got) begin
                            got <= 1'b1;
                            sym <= data_3bits_in[1:0];
                        end
                    end else begin
                        got <= 1'b0;
                        if (!present_c) begin
                            // Missing symbol: drop the partial byte and abort.
                            frame_err <= 1'b1;
                            state     <= HOLDOFF;
                            state_out <= 1'b0;
                            gap       <= '0;
                            sh        <= '0;
                            sym_cnt   <= '0;
                        end else begin
                            sh      <= next_sh_c;
                            sym_cnt <= sym_cnt + 2'd1;
                            if (sym_cnt == 2'd3) begin
                                byte_out   <= next_sh_c;
                                byte_valid <= 1'b1;
                                byte_cnt   <= byte_cnt + 8'd1;
                                if (byte_cnt == 8'(FRAME_BYTES - 1)) begin
                                    frame_done <= 1'b1;
                                    state      <= HOLDOFF;
                                    state_out  <= 1'b0;
                                    gap        <= '0;
                                end
                            end
                        end
                    end
                end
                HOLDOFF: begin
                    if (gap == 8'(SOF_GAP - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        gap <= gap + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
